// File: rtl/ysyx_25020037_icache.sv
// ysyx_25020037_icache: direct-mapped read-only instruction cache with single-pulse line refill.
// Optional macro YSYX_25020037_ICACHE_FENCE_EN adds a fence_i port that invalidates all lines.
module ysyx_25020037_icache #(
  parameter int BLOCK_SIZE = 4,
  parameter int NUM_LINES  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
`ifdef YSYX_25020037_ICACHE_FENCE_EN
  input  logic                    fence_i,
`endif
  input  logic [31:0]             icache_addr,
  output logic [31:0]             icache_data,
  output logic                    icache_hit,
  output logic                    icache_ready,
  output logic                    mem_req,
  output logic [31:0]             mem_addr,
  input  logic [BLOCK_SIZE*8-1:0] mem_data,
  input  logic                    mem_ready,
  input  logic                    mem_err
);
  localparam int OFF = $clog2(BLOCK_SIZE);
  localparam int IDX = $clog2(NUM_LINES);
  localparam int TW  = 32 - OFF - IDX;
  localparam int WW  = (OFF > 2) ? OFF - 2 : 1;
  typedef enum logic {IDLE, MISS} state_e;
  state_e                  state_q, state_d;
  logic [31:0]             miss_addr_q, miss_addr_d;
  logic [NUM_LINES-1:0]    valid_q, valid_d;
  logic                    fence_pend_q, fence_pend_d;
  logic [TW-1:0]           tag_q  [NUM_LINES];
  logic [BLOCK_SIZE*8-1:0] data_q [NUM_LINES];
  logic [IDX-1:0]          idx, midx;
  logic [TW-1:0]           tag;
  logic [WW-1:0]           word;
  logic [31:0]             blk;
  logic                    fence, fill;
`ifdef YSYX_25020037_ICACHE_FENCE_EN
  assign fence = fence_i;
`else
  assign fence = 1'b0;
`endif
  assign idx          = icache_addr[OFF+IDX-1:OFF];
  assign tag          = icache_addr[31:OFF+IDX];
  assign word         = WW'(icache_addr[OFF-1:0] >> 2);
  assign blk          = {icache_addr[31:OFF], {OFF{1'b0}}};
  assign midx         = miss_addr_q[OFF+IDX-1:OFF];
  assign icache_hit   = valid_q[idx] && tag_q[idx] == tag && state_q == IDLE && !fence;
  assign icache_data  = data_q[idx][{word, 5'b0} +: 32];
  assign icache_ready = state_q == IDLE;
  assign mem_req      = !icache_hit;
  assign mem_addr     = state_q == MISS ? miss_addr_q : blk;
  // A fence seen during MISS is deferred so it also kills the line being refilled.
  always_comb begin
    state_d      = state_q;
    miss_addr_d  = miss_addr_q;
    valid_d      = valid_q;
    fence_pend_d = fence_pend_q;
    fill         = 1'b0;
    if (state_q == IDLE) begin
      if (!icache_hit) begin
        state_d     = MISS;
        miss_addr_d = blk;
      end
      if (fence) valid_d = '0;
    end else begin
      fence_pend_d = fence_pend_q | fence;
      if (mem_ready) begin
        state_d       = IDLE;
        fill          = !mem_err;
        valid_d[midx] = !mem_err;
        if (fence_pend_d) valid_d = '0;
        fence_pend_d  = 1'b0;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      miss_addr_q  <= '0;
      valid_q      <= '0;
      fence_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      miss_addr_q  <= miss_addr_d;
      valid_q      <= valid_d;
      fence_pend_q <= fence_pend_d;
    end
  end
  always_ff @(posedge clk) begin
    if (fill) begin
      data_q[midx] <= mem_data;
      tag_q[midx]  <= miss_addr_q[31:OFF+IDX];
    end
  end
endmodule

// File: tb/tb_ysyx_25020037_icache.sv
// tb_ysyx_25020037_icache: directed plan steps plus random traffic checked against a line-map model.
module tb_ysyx_25020037_icache;
  localparam int BS = 16;
  localparam int NL = 16;
  logic          clk = 1'b0, rst_n = 1'b0, mem_ready = 1'b0, mem_err = 1'b0, fence = 1'b0;
  logic [31:0]   addr = '0;
  logic [BS*8-1:0] mem_data = '0;
  logic [31:0]   data, mem_addr;
  logic          hit, ready, req;
  int            ncmp = 0, nfail = 0;
  bit            m_valid [NL];
  logic [31:0]   m_base [NL];
  logic [31:0]   m_w [NL][4];
  bit            m_miss;
  logic [31:0]   m_maddr;

  ysyx_25020037_icache #(.BLOCK_SIZE(BS), .NUM_LINES(NL)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef YSYX_25020037_ICACHE_FENCE_EN
    .fence_i(fence),
`endif
    .icache_addr(addr), .icache_data(data), .icache_hit(hit), .icache_ready(ready),
    .mem_req(req), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] blk_of(logic [31:0] a);
    return {a[31:4], 4'h0};
  endfunction
  function automatic int idx_of(logic [31:0] a);
    return int'(a[7:4]);
  endfunction
  function automatic bit m_hit(logic [31:0] a);
    return !fence && !m_miss && m_valid[idx_of(a)] && m_base[idx_of(a)] == blk_of(a);
  endfunction
  function automatic logic [127:0] rnd_line();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
    m_miss = 1'b0;
  endtask

  task automatic chk(input string t, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", t, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic r, input logic e, input logic [127:0] d);
    addr = a; mem_ready = r; mem_err = e; mem_data = d;
    #1;
  endtask

  task automatic check_model();
    bit h;
    h = m_hit(addr);
    chk("hit", {31'b0, hit}, {31'b0, h});
    chk("ready", {31'b0, ready}, {31'b0, !m_miss});
    chk("req", {31'b0, req}, {31'b0, !h});
    chk("mem_addr", mem_addr, m_miss ? m_maddr : blk_of(addr));
    if (h) chk("data", data, m_w[idx_of(addr)][addr[3:2]]);
  endtask

  task automatic model_edge();
    int i;
    if (!m_miss) begin
      if (!m_hit(addr)) begin
        m_miss  = 1'b1;
        m_maddr = blk_of(addr);
      end
      if (fence) for (int k = 0; k < NL; k++) m_valid[k] = 1'b0;
    end else if (mem_ready) begin
      i = idx_of(m_maddr);
      m_valid[i] = !mem_err;
      if (!mem_err) begin
        m_base[i] = m_maddr;
        for (int k = 0; k < 4; k++) m_w[i][k] = mem_data[k*32 +: 32];
      end
      m_miss = 1'b0;
    end
  endtask

  task automatic tick();
    check_model();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic fill(input logic [31:0] a, input logic [127:0] d, input logic e);
    drive(a, 1'b0, 1'b0, '0); tick();
    drive(a, 1'b1, e, d); tick();
  endtask

  initial begin
    logic [31:0] a;
    m_reset();
    drive(32'h3000_0000, 1'b0, 1'b0, '0);
    chk("rst_ready", {31'b0, ready}, 32'd1);
    chk("rst_hit", {31'b0, hit}, 32'd0);
    chk("rst_req", {31'b0, req}, 32'd1);
    chk("rst_mem_addr", mem_addr, 32'h3000_0000);
    @(posedge clk); #1;
    rst_n = 1'b1;
    // cold miss
    drive(32'h3000_0000, 1'b0, 1'b0, '0);
    chk("cold_hit", {31'b0, hit}, 32'd0);
    chk("cold_req", {31'b0, req}, 32'd1);
    chk("cold_mem_addr", mem_addr, 32'h3000_0000);
    tick();
    chk("miss_ready", {31'b0, ready}, 32'd0);
    drive(32'h3000_0000, 1'b1, 1'b0, {96'h0, 32'h0000_0413}); tick();
    drive(32'h3000_0000, 1'b0, 1'b0, '0);
    chk("refill_hit", {31'b0, hit}, 32'd1);
    chk("refill_data", data, 32'h0000_0413);
    chk("refill_req", {31'b0, req}, 32'd0);
    tick();
    // word select
    fill(32'hA000_0000, {32'd4, 32'd3, 32'd2, 32'd1}, 1'b0);
    drive(32'hA000_0008, 1'b0, 1'b0, '0);
    chk("word2_hit", {31'b0, hit}, 32'd1);
    chk("word2_data", data, 32'd3);
    tick();
    drive(32'hA000_000C, 1'b0, 1'b0, '0);
    chk("word3_data", data, 32'd4);
    tick();
    // conflict eviction on index 0
    fill(32'h3000_0000, rnd_line(), 1'b0);
    fill(32'h3000_0100, rnd_line(), 1'b0);
    drive(32'h3000_0100, 1'b0, 1'b0, '0);
    chk("evict_new_hit", {31'b0, hit}, 32'd1);
    tick();
    drive(32'h3000_0000, 1'b0, 1'b0, '0);
    chk("evict_old_hit", {31'b0, hit}, 32'd0);
    chk("evict_mem_addr", mem_addr, 32'h3000_0000);
    tick();
    drive(32'h3000_0000, 1'b1, 1'b0, rnd_line()); tick();
    // error refill invalidates a previously valid line at that index
    fill(32'h3000_0110, rnd_line(), 1'b0);
    fill(32'h3000_0010, rnd_line(), 1'b1);
    drive(32'h3000_0010, 1'b0, 1'b0, '0);
    chk("err_hit", {31'b0, hit}, 32'd0);
    chk("err_req", {31'b0, req}, 32'd1);
    chk("err_mem_addr", mem_addr, 32'h3000_0010);
    tick();
    drive(32'h3000_0010, 1'b1, 1'b0, rnd_line()); tick();
    fill(32'h3000_0110, rnd_line(), 1'b1);
    drive(32'h3000_0110, 1'b0, 1'b0, '0);
    chk("err_prev_hit", {31'b0, hit}, 32'd0);
    tick();
    drive(32'h3000_0110, 1'b1, 1'b0, rnd_line()); tick();
    // address change during MISS
    drive(32'h3000_0020, 1'b0, 1'b0, '0); tick();
    drive(32'h3000_0054, 1'b1, 1'b0, {32'd8, 32'd7, 32'd6, 32'd5});
    chk("chg_mem_addr", mem_addr, 32'h3000_0020);
    tick();
    drive(32'h3000_0024, 1'b0, 1'b0, '0);
    chk("chg_hit", {31'b0, hit}, 32'd1);
    chk("chg_data", data, 32'd6);
    tick();
    drive(32'h3000_0054, 1'b0, 1'b0, '0);
    chk("chg_other_hit", {31'b0, hit}, 32'd0);
    tick();
    drive(32'h3000_0054, 1'b1, 1'b0, rnd_line()); tick();
    // async reset in MISS, then a late mem_ready
    drive(32'h3000_0030, 1'b0, 1'b0, '0); tick();
    addr = 32'h3000_0100; #1;
    rst_n = 1'b0; #1;
    chk("arst_ready", {31'b0, ready}, 32'd1);
    chk("arst_hit", {31'b0, hit}, 32'd0);
    m_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(32'h3000_0100, 1'b1, 1'b0, rnd_line());
    chk("late_rdy_hit", {31'b0, hit}, 32'd0);
    tick();
    drive(32'h3000_0100, 1'b0, 1'b0, '0);
    chk("late_rdy_ready", {31'b0, ready}, 32'd0);
    tick();
    drive(32'h3000_0100, 1'b1, 1'b0, rnd_line()); tick();
    drive(32'h3000_0100, 1'b0, 1'b0, '0);
    chk("post_rst_hit", {31'b0, hit}, 32'd1);
    tick();
`ifdef YSYX_25020037_ICACHE_FENCE_EN
    fill(32'h3000_0020, rnd_line(), 1'b0);
    fence = 1'b1;
    drive(32'h3000_0100, 1'b0, 1'b0, '0);
    chk("fence_hit", {31'b0, hit}, 32'd0);
    tick();
    fence = 1'b0;
    drive(32'h3000_0100, 1'b1, 1'b1, '0); tick();
    drive(32'h3000_0024, 1'b0, 1'b0, '0);
    chk("fence_other_hit", {31'b0, hit}, 32'd0);
    tick();
    drive(32'h3000_0024, 1'b1, 1'b0, rnd_line()); tick();
`endif
    // random traffic over two tags and four indices
    for (int n = 0; n < 400; n++) begin
      a = 32'h3000_0000 + (32'($urandom_range(0, 1)) << 12) + (32'($urandom_range(0, 3)) << 4)
          + (32'($urandom_range(0, 3)) << 2);
      drive(a, $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0, rnd_line());
      tick();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule

// File: doc/ysyx_25020037_icache.md
Name: ysyx_25020037_icache

Overview:
Direct-mapped, read-only instruction cache that sits directly downstream of the fetch unit's PC and serves it instructions.
- Lookup: the IFU drives icache_addr, and the cache returns icache_data and icache_hit combinationally.
- Miss: the cache raises mem_req with a block-aligned mem_addr. The IFU performs the AXI burst and returns the whole line on mem_data with a one-cycle mem_ready pulse.
- Refill: the line is written on that pulse, so the IFU's next-cycle read of icache_data hits.

Parameters:
- BLOCK_SIZE, 4, line size in bytes. Legal values are 4, 8, 16. Must equal the IFU's BLOCK_SIZE.
- NUM_LINES, 16, number of lines. Power of two, at least 2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- icache_addr  in  32  fetch address (PC) from the IFU.
- icache_data  out  32  instruction word selected by icache_addr.
- icache_hit  out  1  lookup hit.
- icache_ready  out  1  cache is in IDLE and able to accept a lookup.
- mem_req  out  1  refill request to the IFU.
- mem_addr  out  32  block-aligned refill address.
- mem_data  in  BLOCK_SIZE*8  refill line. Word 0 is in bits [31:0].
- mem_ready  in  1  one-cycle pulse: mem_data is valid.
- mem_err  in  1  qualifies mem_ready. When high, the refill response was an error.

Behaviour:
- Address split:
  - OFF = log2(BLOCK_SIZE), IDX = log2(NUM_LINES).
  - offset = addr[OFF-1:0]; index = addr[OFF+IDX-1:OFF]; tag = addr[31:OFF+IDX].
- Storage:
  - valid[NUM_LINES] flops, tag array, data array.
  - Reset clears every valid bit only; tag and data arrays are not reset.
- Lookup is fully combinational, in every state:
  - icache_hit = valid[index] && tag_arr[index]==tag && state==IDLE.
  - icache_data = data_arr[index][addr[OFF-1:2]*32 +: 32]. When BLOCK_SIZE=4, this is the whole line.
  - icache_data is don't-care when icache_hit=0. The bench must not check it then.
- FSM states: IDLE, MISS.
  - IDLE: if icache_hit=0, latch miss_addr = {icache_addr[31:OFF], OFF'b0} and go to MISS next cycle.
  - MISS: hold until mem_ready=1, then return to IDLE.
  - MISS ignores changes on icache_addr; the refill always targets the latched miss_addr.
- mem_req = (state==IDLE && !icache_hit) || state==MISS.
  - It is asserted in the same cycle the miss is seen, because the IFU samples it together with icache_hit.
- mem_addr:
  - In IDLE: the block base of icache_addr.
  - In MISS: miss_addr.
- icache_ready = (state==IDLE).
- Refill, on the clk edge where state==MISS && mem_ready:
  - mem_err=0: write data_arr[idx(miss_addr)] = mem_data, tag_arr = tag(miss_addr), valid = 1. The lookup one cycle later hits.
  - mem_err=1: write nothing and clear valid[idx]. The IFU reports access_fault; the next lookup to that address misses and refetches.
- mem_ready while in IDLE is ignored; the arrays are unchanged.
- Replacement: direct-mapped, so the refill always overwrites the indexed line, whether or not it was valid.
- Reset asserted mid-MISS: state goes to IDLE and all valid bits clear immediately (asynchronous). A mem_ready pulse arriving after reset deassertion is ignored.
- Reset values of outputs:
  - icache_hit=0 (all invalid), icache_ready=1.
  - mem_req=1 with mem_addr equal to the block base of icache_addr, because the first lookup misses.
  - icache_data is don't-care.
- Latency: hit 0 cycles; miss-to-valid-data 1 cycle after the mem_ready edge.

Optional Feature:
- Macro: YSYX_25020037_ICACHE_FENCE_EN.
- Defined:
  - Adds input port fence_i (1 bit).
  - While fence_i=1, icache_hit is forced to 0.
  - At the clk edge where fence_i=1 and state==IDLE, all valid bits clear.
  - fence_i asserted during MISS is held pending. Valid bits are cleared at the refill edge, and the just-written line is also invalidated.
- Not defined: no fence_i port. Valid bits clear only on reset.

Test Plan:
1. Cold miss:
   - Stimulus: release reset, icache_addr=0x30000000.
   - Required: icache_hit=0, mem_req=1, mem_addr=0x30000000.
   - Next cycle: state MISS, icache_ready=0.
   - Then pulse mem_ready with mem_data=0x00000413: following cycle icache_hit=1, icache_data=0x00000413, mem_req=0.
2. Word select, BLOCK_SIZE=16:
   - Stimulus: refill 0xA0000000 with words {W3..W0}={4,3,2,1}.
   - Required: icache_addr=0xA0000008 gives hit with data 3; 0xA000000C gives data 4.
3. Conflict eviction, NUM_LINES=16, BLOCK_SIZE=4:
   - Stimulus: fill 0x30000000, then fill 0x30000040 (same index 0).
   - Required: 0x30000040 hits; 0x30000000 then misses with mem_addr=0x30000000.
4. Error refill:
   - Stimulus: mem_ready=1 with mem_err=1 for 0x30000010.
   - Required: next cycle icache_hit=0 and mem_req=1 again for 0x30000010. A previously valid line at that index is invalidated.
5. Address change during MISS:
   - Stimulus: miss on 0x30000020, then switch icache_addr to 0x30000024 before mem_ready.
   - Required: the refill writes the 0x30000020 line.
   - For BLOCK_SIZE=4: 0x30000020 hits afterwards, 0x30000024 misses.
6. Async reset in MISS, plus fence (with YSYX_25020037_ICACHE_FENCE_EN defined):
   - Stimulus: assert rst_n=0 mid-cycle during MISS.
   - Required: immediately icache_ready=1 and all lines invalid; a late mem_ready is ignored.
   - Stimulus: with lines valid, pulse fence_i in IDLE.
   - Required: next-cycle lookups all miss.
